// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_adder: bit-serial WIDTH-bit adder, one full-adder cell, LSB first |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module full_add (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic fsum,
  output logic c
);

  assign fsum = x ^ y ^ z;
  assign c    = (x & y) | (z & (x ^ y));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_sum;
  logic               fa_carry;

  full_add u_full_add (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .z    (carry_q),
    .fsum (fa_sum),
    .c    (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_adder: randomized and directed checks against an integer model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high and take the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    tick();
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Run the remaining edges of an accepted operation, scribbling on inputs
  // meanwhile; glitch_at>0 forces start=1 with a=0F at that edge.
  task automatic finish_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic vc, input int glitch_at, input bit keep_start);
    logic [WIDTH:0] expected;
    int             k;
    bit             seen;
    expected = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
    seen     = 1'b0;
    k        = 0;
    while (k < WIDTH + 4 && !seen) begin
      k++;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      start = keep_start ? 1'b1 : 1'($urandom);
      if (k == glitch_at) begin
        a     = 8'h0F;
        start = 1'b1;
      end
      tick();
      if (done) seen = 1'b1;
      else      check("run_busy", 32'(busy), 32'd1);
    end
    check("latency", 32'(k), 32'(WIDTH));
    check("done_seen", 32'(seen), 32'd1);
    check("done_not_busy", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(expected[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(expected[WIDTH]));
    if (!keep_start) start = 1'b0;
  endtask

  // Edge after DONE: back in IDLE with the result held.
  task automatic post_done(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    logic [WIDTH:0] expected;
    expected = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
    start    = 1'b0;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_sum", 32'(sum), 32'(expected[WIDTH-1:0]));
    check("hold_cout", 32'(cout), 32'(expected[WIDTH]));
  endtask

  task automatic full_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc, input int glitch_at);
    accept(va, vb, vc);
    finish_op(va, vb, vc, glitch_at, 1'b0);
    post_done(va, vb, vc);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    // Reset with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check("rst_stay_idle", 32'(busy), 32'd0);

    // Directed operations.
    full_op(8'h35, 8'h4A, 1'b0, 0);
    full_op(8'hFF, 8'h01, 1'b0, 0);
    full_op(8'hFF, 8'hFF, 1'b1, 0);
    full_op(8'h00, 8'h00, 1'b0, 0);
    full_op(8'h10, 8'h01, 1'b0, 3);

    // Reset in the middle of RUN.
    accept(8'h55, 8'h22, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    full_op(8'h01, 8'h02, 1'b0, 0);

    // Start held high: back-to-back with one idle cycle in between.
    accept(8'h81, 8'h7F, 1'b0);
    finish_op(8'h81, 8'h7F, 1'b0, 0, 1'b1);
    a     = 8'hC3;
    b     = 8'h5A;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    tick();
    check("b2b_accept", 32'(busy), 32'd1);
    finish_op(8'hC3, 8'h5A, 1'b1, 0, 1'b0);
    post_done(8'hC3, 8'h5A, 1'b1);

    // Randomized operations with random start noise during RUN.
    for (int n = 0; n < 30; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      full_op(ra, rb, rc, int'($urandom_range(0, WIDTH)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
